array_row_multiplier_seq: RTL and testbench

- Sequential unsigned WIDTH x WIDTH multiplier that time-shares one row of 2*WIDTH Array_Multiplier_Cell instances instead of a full WIDTH-row array.
- An FSM plus counter issues one partial-product row per cycle: row input is multiplicand AND current multiplier bit, accumulated into a running sum.
- Valid/ready handshake on both input and output; used where area matters more than throughput.

---
 rtl/array_row_multiplier_seq.sv | 117 +++++++++++
 tb/tb_array_row_multiplier_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/array_row_multiplier_seq.sv
// array_row_multiplier_seq: unsigned WIDTH x WIDTH multiplier reusing one adder row per cycle.
// Optional: define ARRAY_ROW_EARLY_TERM_EN to finish early when the remaining multiplier bits are zero.

// array_multiplier_cell: gated partial-product bit added to a running sum bit and carry.
module array_multiplier_cell (
    input  logic a,
    input  logic b,
    input  logic sumin,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic pp;
    assign pp   = a & b;
    assign sum  = pp ^ sumin ^ cin;
    assign cout = (pp & sumin) | (pp & cin) | (sumin & cin);
endmodule

module array_row_multiplier_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] P,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [PW-1:0]   mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]   acc;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   row_sum;
    logic [PW-1:0]   carry;
    logic            unused_msb_cout;
    logic            last;

    assign carry[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i < PW; i++) begin : g_row
            if (i < PW - 1) begin : g_mid
                array_multiplier_cell u_cell (
                    .a(mcand[i]), .b(mplier[0]), .sumin(acc[i]), .cin(carry[i]),
                    .sum(row_sum[i]), .cout(carry[i+1])
                );
            end else begin : g_msb
                array_multiplier_cell u_cell (
                    .a(mcand[i]), .b(mplier[0]), .sumin(acc[i]), .cin(carry[i]),
                    .sum(row_sum[i]), .cout(unused_msb_cout)
                );
            end
        end
    endgenerate

`ifdef ARRAY_ROW_EARLY_TERM_EN
    assign last = (mplier[WIDTH-1:1] == '0) || (cnt == CW'(WIDTH - 1));
`else
    assign last = (cnt == CW'(WIDTH - 1));
`endif

    // Control FSM, operand shifting and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            P         <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    mcand    <= {{WIDTH{1'b0}}, A};
                    mplier   <= B;
                    acc      <= '0;
                    cnt      <= '0;
                    state    <= RUN;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                end
                RUN: begin
                    acc    <= row_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        P         <= row_sum;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_array_row_multiplier_seq.sv
// tb_array_row_multiplier_seq: directed and random checks of the sequential row multiplier.
module tb_array_row_multiplier_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic [15:0] p;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    int          checks = 0;
    int          failures = 0;

    array_row_multiplier_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .P(p), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input logic [7:0] bv);
`ifdef ARRAY_ROW_EARLY_TERM_EN
        int l = 1;
        for (int k = 0; k < 8; k++) if (bv[k]) l = k + 1;
        return l;
`else
        return 8;
`endif
    endfunction

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv, input logic [15:0] ep);
        int lat;
        check({tag, "_in_ready"}, in_ready, 1);
        a = av;
        b = bv;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_done(lat);
        check({tag, "_lat"}, lat, exp_lat(bv));
        check({tag, "_p"}, p, ep);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_ov_low"}, out_valid, 0);
        check({tag, "_idle_ready"}, in_ready, 1);
    endtask

    initial begin
        int lat;
        logic [15:0] held;
        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_p", p, 0);

        a = 13;
        b = 11;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("t1_busy_run", busy, 1);
        check("t1_ready_run", in_ready, 0);
        wait_done(lat);
        check("t1_lat", lat, exp_lat(8'd11));
        check("t1_p", p, 143);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t1_ready_after", in_ready, 1);
        check("t1_busy_after", busy, 0);
        step();
        check("t1_ready_after2", in_ready, 1);

        run_op("max", 255, 255, 16'hFE01);
        run_op("a0", 0, 200, 0);
        run_op("b0", 200, 0, 0);
        run_op("et_b3", 50, 3, 150);
        run_op("et_b128", 2, 128, 256);

        a = 21;
        b = 6;
        in_valid = 1'b1;
        step();
        wait_done(lat);
        check("bp_p0", p, 126);
        held = p;
        for (int k = 0; k < 5; k++) begin
            a = 8'(k * 37 + 3);
            b = 8'(k * 11 + 5);
            step();
            check("bp_p", p, held);
            check("bp_ov", out_valid, 1);
            check("bp_ready", in_ready, 0);
            check("bp_busy", busy, 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_ov_low", out_valid, 0);
        check("bp_idle", in_ready, 1);
        step();
        check("bp_no_capture", busy, 0);

        a = 100;
        b = 100;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mr_ov", out_valid, 0);
        check("mr_busy", busy, 0);
        check("mr_p", p, 0);
        check("mr_ready", in_ready, 1);
        run_op("mr_next", 7, 9, 63);

        rst = 1'b1;
        in_valid = 1'b1;
        a = 5;
        b = 5;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        check("rv_busy", busy, 0);
        step();
        check("rv_busy2", busy, 0);
        check("rv_ov", out_valid, 0);

        for (int k = 0; k < 1000; k++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op("rnd", ra, rb, 16'(ra) * 16'(rb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
